// File: rtl/ecc_pkg.sv
// Shared SEC-DED helpers: codeword sizing, data-bit placement, encoder, FSM states.
package ecc_pkg;
  localparam int CNT_W  = 8;
  localparam int MAX_CW = 64;
  localparam int IW     = $clog2(MAX_CW);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RDW, S_DEC, S_WB} state_e;

  // Smallest P with 2**P >= DW+P+1
  function automatic int parity_bits(input int dw);
    int p;
    p = 0;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic int cw_width(input int dw);
    return dw + parity_bits(dw) + 1;
  endfunction

  // Codeword position of data bit j: the j-th non-power-of-two index above 0
  function automatic int data_pos(input int j);
    int pos, cnt;
    pos = 0;
    cnt = -1;
    while (cnt < j) begin
      pos++;
      if ((pos & (pos - 1)) != 0) cnt++;
    end
    return pos;
  endfunction

  // Place data, then set Hamming bits so the syndrome is zero, then overall parity in bit 0
  function automatic logic [MAX_CW-1:0] secded_enc(input logic [MAX_CW-1:0] data, input int dw);
    logic [MAX_CW-1:0] cw;
    logic [IW-1:0]     s;
    int                cwn;
    cw  = '0;
    s   = '0;
    cwn = cw_width(dw);
    for (int j = 0; j < MAX_CW; j++) begin
      if (j < dw && data[IW'(j)]) begin
        cw[IW'(data_pos(j))] = 1'b1;
        s = s ^ IW'(data_pos(j));
      end
    end
    for (int p = 0; p < IW; p++) begin
      if ((1 << p) < cwn) cw[IW'(1 << p)] = |(s & IW'(1 << p));
    end
    cw[0] = ^cw;
    return cw;
  endfunction
endpackage

// File: rtl/ecc_mem_ctrl_if.sv
// Host request/response bus of the ECC memory controller.
interface ecc_mem_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_corrected;
  logic          rsp_uncorr;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_corrected, rsp_uncorr
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_corrected, rsp_uncorr
  );
endinterface

// File: rtl/secded_dec.sv
// Combinational SEC-DED decoder: corrects one flipped bit, flags double errors.
module secded_dec
  import ecc_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = cw_width(DW)
) (
  input  logic [CW-1:0] cw_i,
  output logic [DW-1:0] data_o,
  output logic          corrected_o,
  output logic          uncorr_o
);
  localparam int SW = $clog2(CW);

  logic [SW-1:0] syn;
  logic          pe;
  logic [CW-1:0] fixed;

  assign pe = ^cw_i;

  // Syndrome: XOR of the indices of all set bits above bit 0
  always_comb begin
    syn = '0;
    for (int i = 1; i < CW; i++) begin
      if (cw_i[i]) syn = syn ^ SW'(i);
    end
  end

  // Classify and repair; s=0 with pe=1 means only the overall parity bit flipped
  always_comb begin
    fixed       = cw_i;
    corrected_o = 1'b0;
    uncorr_o    = 1'b0;
    if (pe) begin
      if (int'(syn) < CW) begin
        corrected_o = 1'b1;
        fixed[syn]  = ~cw_i[syn];
      end else begin
        uncorr_o = 1'b1;
      end
    end else if (syn != '0) begin
      uncorr_o = 1'b1;
    end
  end

  for (genvar j = 0; j < DW; j++) begin : g_data
    assign data_o[j] = fixed[data_pos(j)];
  end
endmodule

// File: rtl/ecc_mem_ctrl.sv
// SEC-DED memory controller: encodes host writes, decodes/corrects reads, optional scrub write-back.
module ecc_mem_ctrl
  import ecc_pkg::*;
#(
  parameter  int AW    = 4,
  parameter  int DW    = 8,
  parameter  int SCRUB = 1,
  localparam int CW    = cw_width(DW)
) (
  input  logic             clk,
  input  logic             rst_n,
  ecc_mem_ctrl_if.slave    host,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rw,
  output logic [CW-1:0]    mem_wdata,
  input  logic [CW-1:0]    mem_rdata
);
  state_e           state_q, state_d;
  logic [AW-1:0]    mem_addr_q;
  logic             mem_rw_q;
  logic [CW-1:0]    mem_wdata_q, cw_q;
  logic             rsp_valid_q, rsp_corr_q, rsp_unc_q;
  logic [DW-1:0]    rsp_rdata_q;
  logic [CNT_W-1:0] corr_cnt_q, uncorr_cnt_q;
  logic             accept;
  logic [DW-1:0]    dec_data;
  logic             dec_corr, dec_unc;

  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    logic [MAX_CW-1:0] full;
    full = secded_enc(MAX_CW'(d), DW);
    return full[CW-1:0];
  endfunction

  secded_dec #(.DW(DW), .CW(CW)) u_dec (
    .cw_i        (cw_q),
    .data_o      (dec_data),
    .corrected_o (dec_corr),
    .uncorr_o    (dec_unc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; busy states ignore requests
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = host.req_write ? S_WR : S_RDW;
      S_WR:    state_d = S_IDLE;
      S_RDW:   state_d = S_DEC;
      S_DEC:   state_d = (dec_corr && SCRUB != 0) ? S_WB : S_IDLE;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    host.req_ready = (state_q == S_IDLE);
    accept         = host.req_valid && (state_q == S_IDLE);
  end

  // Registered RAM drive, response and counters; reset also blocks any pending RAM write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q   <= '0;
      mem_rw_q     <= 1'b0;
      mem_wdata_q  <= '0;
      cw_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_corr_q   <= 1'b0;
      rsp_unc_q    <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (accept) begin
          mem_addr_q <= host.req_addr;
          mem_rw_q   <= host.req_write;
          if (host.req_write) mem_wdata_q <= enc(host.req_wdata);
        end
        S_WR:  mem_rw_q <= 1'b0;
        S_RDW: cw_q <= mem_rdata;
        S_DEC: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= dec_data;
          rsp_corr_q  <= dec_corr;
          rsp_unc_q   <= dec_unc;
          if (dec_corr && corr_cnt_q != {CNT_W{1'b1}}) corr_cnt_q <= corr_cnt_q + 1'b1;
          if (dec_unc && uncorr_cnt_q != {CNT_W{1'b1}}) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
          if (dec_corr && SCRUB != 0) begin
            mem_wdata_q <= enc(dec_data);
            mem_rw_q    <= 1'b1;
          end
        end
        S_WB:    mem_rw_q <= 1'b0;
        default: mem_rw_q <= 1'b0;
      endcase
    end
  end

  assign mem_addr           = mem_addr_q;
  assign mem_rw             = mem_rw_q;
  assign mem_wdata          = mem_wdata_q;
  assign host.rsp_valid     = rsp_valid_q;
  assign host.rsp_rdata     = rsp_rdata_q;
  assign host.rsp_corrected = rsp_corr_q;
  assign host.rsp_uncorr    = rsp_unc_q;
  assign corr_cnt           = corr_cnt_q;
  assign uncorr_cnt         = uncorr_cnt_q;
endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Bench for ecc_mem_ctrl: two instances (scrub on/off), each with a falling-edge RAM model.
module tb_ecc_mem_ctrl;
  localparam int AW = 4, DW = 8, CW = 13;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  ecc_mem_ctrl_if #(.AW(AW), .DW(DW)) h();
  ecc_mem_ctrl_if #(.AW(AW), .DW(DW)) h0();

  logic [7:0]    cc, uc, cc0, uc0;
  logic [AW-1:0] ma, ma0;
  logic          mrw, mrw0;
  logic [CW-1:0] mwd, mrd, mwd0, mrd0;
  logic [CW-1:0] ram [16];
  logic [CW-1:0] ram0[16];
  logic [CW-1:0] watch_cw = '0;
  int            wr_hits = 0, rsp_pulses = 0;
  int            checks = 0, fails = 0;
  logic [7:0]    exp_mem[16];
  int            exp_cc = 0, exp_uc = 0;

  ecc_mem_ctrl #(.AW(AW), .DW(DW), .SCRUB(1)) dut (
    .clk(clk), .rst_n(rst_n), .host(h.slave), .corr_cnt(cc), .uncorr_cnt(uc),
    .mem_addr(ma), .mem_rw(mrw), .mem_wdata(mwd), .mem_rdata(mrd));
  ecc_mem_ctrl #(.AW(AW), .DW(DW), .SCRUB(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .host(h0.slave), .corr_cnt(cc0), .uncorr_cnt(uc0),
    .mem_addr(ma0), .mem_rw(mrw0), .mem_wdata(mwd0), .mem_rdata(mrd0));

  // RAMs commit writes and present read data on the falling edge
  always @(negedge clk) begin
    if (mrw === 1'b1) begin
      ram[ma] = mwd;
      if (mwd === watch_cw) wr_hits++;
    end
    mrd = ram[ma];
    if (h.rsp_valid === 1'b1) rsp_pulses++;
    if (mrw0 === 1'b1) ram0[ma0] = mwd0;
    mrd0 = ram0[ma0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reference extended-Hamming code, written from the layout rules directly
  function automatic logic [12:0] ref_enc(input logic [7:0] d);
    int pos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [12:0] c = '0;
    for (int j = 0; j < 8; j++) c[pos[j]] = d[j];
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 8; j++)
        if (((pos[j] >> p) & 1) == 1) c[1 << p] = c[1 << p] ^ d[j];
    c[0] = ^c[12:1];
    return c;
  endfunction

  function automatic logic [7:0] ref_raw(input logic [12:0] c);
    int pos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [7:0] d = '0;
    for (int j = 0; j < 8; j++) d[j] = c[pos[j]];
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready;
    int n = 0;
    while (h.req_ready !== 1'b1 && n < 20) begin tick; n++; end
    if (n >= 20) chk("ready_timeout", {31'b0, h.req_ready}, 1);
  endtask

  task automatic hwrite(input logic [3:0] a, input logic [7:0] d);
    wait_ready;
    h.req_valid = 1; h.req_write = 1; h.req_addr = a; h.req_wdata = d;
    tick;
    h.req_valid = 0; h.req_write = 0;
    tick;
    exp_mem[a] = d;
  endtask

  task automatic hread(input logic [3:0] a, output logic [7:0] d, output logic c, output logic u,
                       output int lat, output int npulse, output logic wb, output logic [3:0] wb_addr);
    wait_ready;
    h.req_valid = 1; h.req_write = 0; h.req_addr = a;
    tick;
    h.req_valid = 0;
    lat = -1; npulse = 0; wb = 0; wb_addr = 0; d = 0; c = 0; u = 0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (h.rsp_valid === 1'b1) begin
        npulse++;
        if (lat < 0) begin lat = k; d = h.rsp_rdata; c = h.rsp_corrected; u = h.rsp_uncorr; end
      end
      if (mrw === 1'b1) begin wb = 1; wb_addr = ma; end
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  initial begin
    logic [7:0] d, wd;
    logic       c, u, wb;
    logic [3:0] wa, a;
    int         lat, np, busy, b1, b2, errs;
    logic [12:0] bad;

    for (int i = 0; i < 16; i++) begin ram[i] = '0; ram0[i] = '0; exp_mem[i] = 8'h00; end
    h.req_valid = 0; h.req_write = 0; h.req_addr = 0; h.req_wdata = 0;
    h0.req_valid = 0; h0.req_write = 0; h0.req_addr = 0; h0.req_wdata = 0;

    // Reset state
    tick; tick;
    chk("rst_ready", {31'b0, h.req_ready}, 1);
    chk("rst_memrw", {31'b0, mrw}, 0);
    chk("rst_rspv", {31'b0, h.rsp_valid}, 0);
    rst_n = 1;
    tick;

    // Write then clean read, latency and single pulse
    hwrite(3, 8'hA5);
    chk("enc_word", ram[3], ref_enc(8'hA5));
    hread(3, d, c, u, lat, np, wb, wa);
    chk("rd_data", d, 8'hA5); chk("rd_corr", c, 0); chk("rd_unc", u, 0);
    chk("rd_lat", lat, 2); chk("rd_pulses", np, 1); chk("rd_nowb", wb, 0);

    // Single-bit error with scrub
    ram[3][5] = ~ram[3][5];
    hread(3, d, c, u, lat, np, wb, wa);
    exp_cc = sat(exp_cc + 1);
    chk("sb_data", d, 8'hA5); chk("sb_corr", c, 1); chk("sb_unc", u, 0);
    chk("sb_wb", wb, 1); chk("sb_wbaddr", wa, 3); chk("sb_cnt", cc, exp_cc);
    chk("sb_scrubbed", ram[3], ref_enc(8'hA5));
    hread(3, d, c, u, lat, np, wb, wa);
    chk("sb_reread_corr", c, 0);

    // Double-bit error, then overall-parity-only error
    ram[3] = ram[3] ^ 13'h0220;
    bad = ram[3];
    hread(3, d, c, u, lat, np, wb, wa);
    exp_uc = sat(exp_uc + 1);
    chk("db_unc", u, 1); chk("db_corr", c, 0); chk("db_nowb", wb, 0);
    chk("db_raw", d, ref_raw(bad)); chk("db_cnt", uc, exp_uc);
    ram[3] = ref_enc(8'hA5) ^ 13'h0001;
    hread(3, d, c, u, lat, np, wb, wa);
    exp_cc = sat(exp_cc + 1);
    chk("p0_data", d, 8'hA5); chk("p0_corr", c, 1); chk("p0_cnt", cc, exp_cc);

    // Reset in the middle of a write, before the RAM commit edge
    hwrite(7, 8'h3C);
    wait_ready;
    h.req_valid = 1; h.req_write = 1; h.req_addr = 7; h.req_wdata = 8'hFF;
    tick;
    chk("mid_wr_rw", {31'b0, mrw}, 1);
    rst_n = 0;
    #1;
    chk("rst_rw_low", {31'b0, mrw}, 0);
    h.req_valid = 0; h.req_write = 0;
    @(negedge clk); #1;
    chk("rst_ram_kept", ram[7], ref_enc(8'h3C));
    tick;
    rst_n = 1;
    exp_cc = 0; exp_uc = 0;
    tick;
    chk("post_rst_ready", {31'b0, h.req_ready}, 1);
    chk("post_rst_rspv", {31'b0, h.rsp_valid}, 0);
    chk("post_rst_cc", cc, 0); chk("post_rst_uc", uc, 0);

    // Held request: read (with scrub) followed by a write while busy
    ram[3][2] = ~ram[3][2];
    watch_cw = ref_enc(8'h5A); wr_hits = 0; rsp_pulses = 0;
    wait_ready;
    h.req_valid = 1; h.req_write = 0; h.req_addr = 3;
    tick;
    h.req_write = 1; h.req_wdata = 8'h5A;
    busy = 0;
    while (h.req_ready !== 1'b1 && busy < 10) begin busy++; tick; end
    tick;
    h.req_valid = 0; h.req_write = 0;
    tick; tick;
    exp_cc = sat(exp_cc + 1);
    exp_mem[3] = 8'h5A;
    chk("hold_busy", busy, 3); chk("hold_wr_once", wr_hits, 1);
    chk("hold_rsp_once", rsp_pulses, 1); chk("hold_cc", cc, exp_cc);
    hread(3, d, c, u, lat, np, wb, wa);
    chk("hold_data", d, 8'h5A); chk("hold_corr", c, 0);

    // Randomized operations against the reference model
    for (int it = 0; it < 60; it++) begin
      a = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin wd = 8'($urandom); hwrite(a, wd); chk("r_enc", ram[a], ref_enc(wd)); end
        1: begin
          hread(a, d, c, u, lat, np, wb, wa);
          chk("r_clean_data", d, exp_mem[a]); chk("r_clean_flags", {c, u}, 0);
        end
        2: begin
          b1 = $urandom_range(0, 12);
          ram[a][b1] = ~ram[a][b1];
          hread(a, d, c, u, lat, np, wb, wa);
          exp_cc = sat(exp_cc + 1);
          chk("r_sb_data", d, exp_mem[a]); chk("r_sb_flags", {c, u}, 2'b10);
          chk("r_sb_wb", {wb, wa}, {1'b1, a}); chk("r_sb_cnt", cc, exp_cc);
        end
        default: begin
          b1 = $urandom_range(0, 12);
          b2 = (b1 + $urandom_range(1, 12)) % 13;
          ram[a][b1] = ~ram[a][b1];
          ram[a][b2] = ~ram[a][b2];
          bad = ram[a];
          hread(a, d, c, u, lat, np, wb, wa);
          exp_uc = sat(exp_uc + 1);
          chk("r_db_raw", d, ref_raw(bad)); chk("r_db_flags", {c, u, wb}, 3'b010);
          chk("r_db_cnt", uc, exp_uc);
          hwrite(a, exp_mem[a]);
        end
      endcase
    end

    // Saturation of the corrected counter
    hwrite(5, 8'hC3);
    errs = 0;
    for (int it = 0; it < 260; it++) begin
      b1 = $urandom_range(0, 12);
      ram[5][b1] = ~ram[5][b1];
      hread(5, d, c, u, lat, np, wb, wa);
      exp_cc = sat(exp_cc + 1);
      if (d !== 8'hC3 || c !== 1'b1) errs++;
    end
    chk("sat_errs", errs, 0);
    chk("sat_cc", cc, exp_cc);
    chk("sat_cc_ff", cc, 8'hFF);

    // No-scrub instance: corrected read, no write-back, error persists
    h0.req_valid = 1; h0.req_write = 1; h0.req_addr = 2; h0.req_wdata = 8'h77;
    tick;
    h0.req_valid = 0; h0.req_write = 0;
    tick;
    ram0[2][6] = ~ram0[2][6];
    for (int rep = 0; rep < 2; rep++) begin
      h0.req_valid = 1; h0.req_addr = 2;
      tick;
      h0.req_valid = 0;
      wb = 0; d = 0; c = 0;
      for (int k = 1; k <= 5; k++) begin
        tick;
        if (mrw0 === 1'b1) wb = 1;
        if (h0.rsp_valid === 1'b1) begin d = h0.rsp_rdata; c = h0.rsp_corrected; end
      end
      chk("ns_data", d, 8'h77); chk("ns_corr", c, 1); chk("ns_nowb", wb, 0);
    end
    chk("ns_persist", ram0[2], ref_enc(8'h77) ^ 13'h0040);
    chk("ns_cnt", cc0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
